// File: rtl/pipelined_rca_adder_if.sv
// Operand/result bus for pipelined_rca_adder.
// master: operand producer and result consumer (drives operands and out_ready).
// slave:  the adder itself.
interface pipelined_rca_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );
endinterface

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor. Each SEG-bit segment is one pipeline stage; the carry
// between segments is registered, and the not-yet-added operand segments travel alongside in
// skew registers. The final stage is the reset output register.
// Optional feature macro: RCA_SUB_EN (enables A-B through the sub input).
module pipelined_rca_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_rca_adder_if.slave bus
);

  localparam int unsigned STAGES = WIDTH / SEG;
  localparam int unsigned Last   = STAGES - 1;
  // Intermediate stages 0..STAGES-2; sized at least 1 so the single-stage build stays legal.
  localparam int unsigned Mid    = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int unsigned CntW   = $clog2(STAGES + 1) + 1;

  logic             adv, accept, drain;
  logic [WIDTH-1:0] b_eff;
  logic             ci_eff;

  // Intermediate stage registers.
  logic [WIDTH-1:0] a_q  [Mid];
  logic [WIDTH-1:0] b_q  [Mid];
  logic [WIDTH-1:0] ps_q [Mid];
  logic [Mid-1:0]   cy_q;
  logic [Mid-1:0]   vld_q;

  // Per-stage inputs (from previous stage or the input boundary) and adder results.
  logic [WIDTH-1:0] src_a  [STAGES];
  logic [WIDTH-1:0] src_b  [STAGES];
  logic [WIDTH-1:0] src_s  [STAGES];
  logic [WIDTH-1:0] res_s  [STAGES];
  logic [SEG:0]     seg_sum[STAGES];
  logic [STAGES-1:0] src_c, src_v, res_c;
  logic             res_ovf;

  // Output (final stage) registers and in-flight counter.
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q, ovf_q;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign adv    = !out_valid_q || bus.out_ready;
  assign accept = bus.in_valid && adv;
  assign drain  = out_valid_q && bus.out_ready;

  // Effective operands: subtract is A + ~B + 1, applied before stage 0.
  always_comb begin
    b_eff  = bus.in_b;
    ci_eff = bus.c_in;
`ifdef RCA_SUB_EN
    if (bus.sub) begin
      b_eff  = ~bus.in_b;
      ci_eff = 1'b1;
    end
`endif
  end

`ifndef RCA_SUB_EN
  logic unused_sub;
  assign unused_sub = bus.sub;
`endif

  // Per-stage segment add; stage k adds segment k onto the carry from stage k-1.
  always_comb begin
    src_a[0] = bus.in_a;
    src_b[0] = b_eff;
    src_s[0] = '0;
    src_c[0] = ci_eff;
    src_v[0] = accept;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = ps_q[k-1];
      src_c[k] = cy_q[k-1];
      src_v[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, src_b[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, src_c[k]};
      res_s[k]   = src_s[k];
      res_s[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      res_c[k]   = seg_sum[k][SEG];
    end
    // Carry into the MSB is a^b^s at that bit; overflow is it XOR carry out.
    res_ovf = src_a[Last][WIDTH-1] ^ src_b[Last][WIDTH-1] ^ res_s[Last][WIDTH-1] ^ res_c[Last];
  end

  // In-flight beat count: accepted but not yet drained.
  always_comb begin
    cnt_d = cnt_q;
    case ({accept, drain})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Valid bits, counter and the output register (reset state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (adv) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          vld_q[k] <= src_v[k];
        end
        out_valid_q <= src_v[Last];
        // Bubbles leave the last result on the output pins.
        if (src_v[Last]) begin
          sum_q   <= res_s[Last];
          c_out_q <= res_c[Last];
          ovf_q   <= res_ovf;
        end
      end
    end
  end

  // Intermediate datapath; not reset, loaded only for valid beats.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES - 1; k++) begin
      if (adv && src_v[k]) begin
        a_q[k]  <= src_a[k];
        b_q[k]  <= src_b[k];
        ps_q[k] <= res_s[k];
        cy_q[k] <= res_c[k];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (cnt_q != '0);

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed bench for pipelined_rca_adder: default 32/4 instance plus an 8/8 single-stage instance.
module tb_pipelined_rca_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_rca_adder_if #(.WIDTH(32)) bus ();
  pipelined_rca_adder_if #(.WIDTH(8))  bus8 ();

  pipelined_rca_adder #(.WIDTH(32), .SEG(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipelined_rca_adder #(.WIDTH(8), .SEG(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_s[$];
  logic        exp_c[$];
  logic        exp_o[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic s);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.c_in     = ci;
    bus.sub      = s;
  endtask

  // Reference: plain wide add, overflow by the sign rule.
  task automatic model_push(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] r;
    r = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    exp_s.push_back(r[31:0]);
    exp_c.push_back(r[32]);
    exp_o.push_back((a[31] == b[31]) && (r[31] != a[31]));
  endtask

  task automatic check_head(input string tag);
    logic [31:0] es;
    logic        ec, eo;
    if (exp_s.size() == 0) begin
      chk(tag, 32'd1, 32'd0);
    end else begin
      es = exp_s.pop_front();
      ec = exp_c.pop_front();
      eo = exp_o.pop_front();
      chk(tag, bus.sum, es);
      chk(tag, 32'(bus.c_out), 32'(ec));
      chk(tag, 32'(bus.ovf), 32'(eo));
    end
  endtask

  // One beat, bounded wait for the result, then compare against hand values.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic s, input logic [31:0] es,
                        input logic ec, input logic eo);
    drive(a, b, ci, s);
    tick();
    bus.in_valid = 1'b0;
    bus.sub      = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) break;
      tick();
    end
    chk(tag, 32'(bus.out_valid), 32'd1);
    chk(tag, bus.sum, es);
    chk(tag, 32'(bus.c_out), 32'(ec));
    chk(tag, 32'(bus.ovf), 32'(eo));
    tick();
  endtask

  initial begin
    int rcv;
    logic [31:0] held, ra, rb;
    logic        rc;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.c_in      = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_a      = '0;
    bus8.in_b      = '0;
    bus8.c_in      = 1'b0;
    bus8.sub       = 1'b0;
    bus8.out_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_sum", bus.sum, 32'h0);
    chk("rst_c_out", 32'(bus.c_out), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst8_out_valid", 32'(bus8.out_valid), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // FFFFFFFF + 1: latency 8, busy for 8 cycles
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("lat_busy_0", 32'(bus.busy), 32'd1);
    chk("lat_valid_0", 32'(bus.out_valid), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("lat_busy", 32'(bus.busy), 32'd1);
      chk("lat_valid", 32'(bus.out_valid), 32'(i == 7));
    end
    chk("lat_sum", bus.sum, 32'h0);
    chk("lat_c_out", 32'(bus.c_out), 32'd1);
    chk("lat_ovf", 32'(bus.ovf), 32'd0);
    tick();
    chk("lat_drained_valid", 32'(bus.out_valid), 32'd0);
    chk("lat_drained_busy", 32'(bus.busy), 32'd0);

    // 16 back-to-back random beats
    rcv = 0;
    for (int t = 0; t < 28; t++) begin
      if (t < 16) begin
        ra = $urandom();
        rb = $urandom();
        rc = 1'($urandom_range(0, 1));
        drive(ra, rb, rc, 1'b0);
        model_push(ra, rb, rc);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      chk("b2b_valid", 32'(bus.out_valid), 32'(t >= 7 && t < 23));
      if (bus.out_valid) begin
        check_head("b2b_data");
        rcv++;
      end
    end
    chk("b2b_count", 32'(rcv), 32'd16);

    // Fill the pipe with the consumer stalled
    bus.out_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'(j & 1);
      drive(ra, rb, rc, 1'b0);
      model_push(ra, rb, rc);
      tick();
    end
    chk("stall_full_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_full_ready", 32'(bus.in_ready), 32'd0);
    held = exp_s[0];
    drive(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0); // must not be accepted
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_sum", bus.sum, held);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rcv = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) begin
        check_head("drain_data");
        rcv++;
      end
      tick();
    end
    chk("drain_count", 32'(rcv), 32'd8);
    chk("drain_busy", 32'(bus.busy), 32'd0);
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

`ifdef RCA_SUB_EN
    single("sub_5m7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    single("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`else
    // Without subtract, sub is ignored
    single("sub_ignored", 32'd5, 32'd7, 1'b1, 1'b1, 32'd13, 1'b0, 1'b0);
    single("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`endif

    // Reset with 4 beats in flight
    for (int j = 0; j < 4; j++) begin
      drive(32'h1000_0000 * j, 32'h0000_0003, 1'b0, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    drive(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_valid_0", 32'(bus.out_valid), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("post_rst_valid", 32'(bus.out_valid), 32'(i == 7));
    end
    chk("post_rst_sum", bus.sum, 32'h2345_678A);
    chk("post_rst_c_out", 32'(bus.c_out), 32'd0);
    tick();

    // Single-stage 8/8 instance: latency 1
    bus8.in_valid = 1'b1;
    bus8.in_a     = 8'hFF;
    bus8.in_b     = 8'h01;
    bus8.c_in     = 1'b1;
    chk("w8_pre_valid", 32'(bus8.out_valid), 32'd0);
    tick();
    bus8.in_valid = 1'b0;
    chk("w8_valid", 32'(bus8.out_valid), 32'd1);
    chk("w8_sum", 32'(bus8.sum), 32'h01);
    chk("w8_c_out", 32'(bus8.c_out), 32'd1);
    chk("w8_ovf", 32'(bus8.ovf), 32'd0);
    tick();
    chk("w8_drained", 32'(bus8.out_valid), 32'd0);
    chk("w8_busy", 32'(bus8.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_rca_adder.md
# pipelined_rca_adder

Parametrised, pipelined ripple-carry adder/subtractor that generalises the team's fixed 32-bit, 4-bit-segment adder to any width and segment size. It registers the carry chain between segments, so each segment occupies one pipeline stage. Throughput is one operation per cycle under a valid/ready handshake. It sits between operand producers (register file, DMA) and result consumers wherever a long combinational carry chain would limit clock frequency.

## Interface
- `WIDTH`, 32: operand and sum width in bits; must be a multiple of `SEG`.
- `SEG`, 4: bits per segment, which is also bits added per pipeline stage. `STAGES = WIDTH/SEG`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  adder can accept a beat this cycle.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `c_in`  in  1  carry in (ignored when `sub`=1 with subtract enabled).
- `sub`  in  1  1 = A−B (only with `RCA_SUB_EN`).
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  WIDTH  result.
- `c_out`  out  1  carry out of MSB; for subtract, 1 = no borrow.
- `ovf`  out  1  two's-complement overflow.
- `busy`  out  1  at least one beat is in flight or held at the output.

## Operation
- Each pipe stage k (0..STAGES−1) holds:
  - a valid bit;
  - the carry out of segment k;
  - sum segments 0..k computed so far;
  - the not-yet-added A/B segments k+1..STAGES−1 (operand skew registers).
- Stage k adds segment k of A and B to the carry registered by stage k−1. Stage 0 uses the effective carry in.
- Effective operands: A is `in_a`. B is `~in_b` when subtracting, else `in_b`. Carry in is 1 when subtracting, else `c_in`. Inversion happens at the input boundary, before stage 0.
- Final stage supplies `sum`, `c_out`, `ovf` and `out_valid`.
  - `ovf` = carry into MSB XOR carry out of MSB. The final stage computes it from its segment's internal carry.
- Pipeline advance: `adv = !out_valid || out_ready`. The whole pipe shifts one stage when `adv`=1 and holds when `adv`=0.
- `in_ready = adv`. A beat is accepted on `in_valid && in_ready`. When `adv`=1 and no beat is accepted, a bubble (valid=0) enters stage 0.
- In-flight counter, width clog2(STAGES+1)+1:
  - +1 on accept; −1 on `out_valid && out_ready`; unchanged when both occur.
  - `busy = (count != 0)`.
  - Count never exceeds STAGES.
- Datapath registers are not reset. Only valid bits and the counter are reset.

## Timing
- Reset (asynchronous assert, synchronous deassert externally):
  - all valid bits = 0 and counter = 0;
  - `out_valid`=0, `busy`=0, `in_ready`=1;
  - `sum`, `c_out`, `ovf` read 0 (output register reset).
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N+STAGES−1, i.e. STAGES cycles after acceptance (8 for the defaults).
- Throughput: 1 beat/cycle while `out_ready`=1.
- Stall: while `out_valid && !out_ready`, all outputs stay stable and `in_ready`=0.
- Bubbles are not compacted. Simultaneous accept and drain in the same cycle is legal.
- Reset mid-operation drops all in-flight beats. No partial result is ever presented.
- `WIDTH`=`SEG` degenerates to a single registered stage with latency 1.

## Configuration
- `RCA_SUB_EN` defined:
  - the `sub` port selects A−B;
  - B is inverted and carry in forced to 1;
  - `sub` is captured with the beat, so mode can change every beat.
- `RCA_SUB_EN` undefined:
  - `sub` is ignored and no inverter is built;
  - result is always A+B+`c_in`.

## Test plan
- Defaults, `in_a`=0xFFFFFFFF, `in_b`=0x00000001, `c_in`=0, `out_ready`=1 → 8 cycles later `sum`=0x00000000, `c_out`=1, `ovf`=0; `busy` high for those 8 cycles.
- 16 back-to-back random beats with `out_ready`=1 → 16 consecutive results matching the reference model, with no gaps after the first 8-cycle latency.
- Fill the pipe, then hold `out_ready`=0 for 5 cycles → `in_ready`=0, and `sum` is held at its value at the start of the stall. After release, all 8 results drain in order with none lost or duplicated.
- `RCA_SUB_EN` set:
  - 5−7 → `sum`=0xFFFFFFFE, `c_out`=0;
  - 0x7FFFFFFF+1 (`sub`=0) → `sum`=0x80000000, `ovf`=1;
  - 0x80000000−1 → `sum`=0x7FFFFFFF, `ovf`=1.
- Assert `rst_n`=0 with 4 beats in flight → `out_valid`=0, `busy`=0 immediately. After release, the first new beat's result appears after 8 cycles with no stale result before it.
- `WIDTH`=8, `SEG`=8, 0xFF+0x01+`c_in`=1 → 1 cycle later `sum`=0x01, `c_out`=1.
